// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit 7-segment scan display.
// Segment codes are active-low {g,f,e,d,c,b,a}; anode codes are active-low,
// with bit 0 driving the rightmost digit.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Scan slot index: 0 = rightmost digit (minutes ones) .. 3 = leftmost.
    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t IDX_DP   = 2'd2;  // slot carrying the colon dot
    localparam digit_idx_t IDX_LAST = 2'd3;  // last slot of a frame

    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D3  = 4'b0111;

    // Per-frame copy of what is being shown: dig[0]=min_1s .. dig[3]=hr_10s,
    // plus the display mode so the dot behaviour switches on a frame edge too.
    typedef struct packed {
        logic            alarm;
        logic [3:0][3:0] dig;
    } snap_t;

    // Active-low anode pattern for a slot.
    function automatic logic [3:0] an_for(input digit_idx_t idx);
        logic [3:0] a;
        a = AN_D0;
        case (idx)
            2'd0: a = AN_D0;
            2'd1: a = AN_D1;
            2'd2: a = AN_D2;
            2'd3: a = AN_D3;
            default: a = AN_OFF;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Table lookup, anything outside 0..9 is flagged with a dash.
    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Basys3 4-digit common-anode scan driver for the HH:MM clock.
// Scans one digit per REFRESH_DIV cycles, blanks all anodes for the first
// BLANK_CYCLES of each slot, and samples the digit source once per frame so
// a frame is always drawn from a single coherent value.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN: suppress a leading zero in
// the tens-of-hours digit (its anode stays enabled, segments all off).
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       tick_1Hz,
    input  logic       show_alarm,
    input  logic [3:0] hr_10s,
    input  logic [3:0] hr_1s,
    input  logic [3:0] min_10s,
    input  logic [3:0] min_1s,
    input  logic [3:0] alarm_hr_10s,
    input  logic [3:0] alarm_hr_1s,
    input  logic [3:0] alarm_min_10s,
    input  logic [3:0] alarm_min_1s,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int               CNT_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;
    snap_t            snap_q, snap_d;

    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;

    logic       slot_end;
    logic       frame_end;
    logic [3:0] cur_dig;
    logic [6:0] dec_seg;

    // Next state of the slot counter, digit index and frame snapshot.
    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
        cnt_d     = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
        snap_d    = snap_q;
        if (frame_end) begin
            snap_d.alarm = show_alarm;
            snap_d.dig   = show_alarm
                         ? {alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s}
                         : {hr_10s, hr_1s, min_10s, min_1s};
        end
    end

    // Scan state registers.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
        end
    end

    assign cur_dig = snap_q.dig[idx_q];

    bcd_to_seg7 u_dec (
        .bcd_i (cur_dig),
        .seg_o (dec_seg)
    );

    // Pin values for the current slot; the dot is only ever lit in slot 2,
    // steady in alarm mode and following the live 1 Hz level in time mode.
    always_comb begin
        an_d  = (cnt_q < CNT_BLANK) ? AN_OFF : an_for(idx_q);
        seg_d = dec_seg;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (idx_q == IDX_LAST && cur_dig == 4'd0)
            seg_d = SEG_OFF;
`endif
        dp_d = 1'b1;
        if (idx_q == IDX_DP)
            dp_d = snap_q.alarm ? 1'b0 : ~tick_1Hz;
    end

    // Registered board outputs, one cycle behind the scan counter.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display at REFRESH_DIV=8, BLANK_CYCLES=2 (32-cycle frame).
// A position-based model predicts every output cycle; directed literal checks
// pin the model against hand-worked values.
module tb_seg7_scan_display;

    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic       tick_1Hz, show_alarm;
    logic [3:0] hr_10s, hr_1s, min_10s, min_1s;
    logic [3:0] alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_tests = 0;
    int n_fail  = 0;

    seg7_scan_display #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
        .clk_100MHz    (clk_100MHz),
        .reset         (reset),
        .tick_1Hz      (tick_1Hz),
        .show_alarm    (show_alarm),
        .hr_10s        (hr_10s),
        .hr_1s         (hr_1s),
        .min_10s       (min_10s),
        .min_1s        (min_1s),
        .alarm_hr_10s  (alarm_hr_10s),
        .alarm_hr_1s   (alarm_hr_1s),
        .alarm_min_10s (alarm_min_10s),
        .alarm_min_1s  (alarm_min_1s),
        .an            (an),
        .seg           (seg),
        .dp            (dp)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // ---------------- model ----------------
    function automatic logic [6:0] dec(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    int         pos = 0;      // clock edges taken since reset release
    int         msnap[4];     // shown digits, [0]=min_1s .. [3]=hr_10s
    bit         malarm = 1'b0;
    logic [3:0] exp_an  = 4'b1111;
    logic [6:0] exp_seg = 7'b1111111;
    logic       exp_dp  = 1'b1;

    always @(posedge clk_100MHz) begin
        if (reset) begin
            pos = 0;
            for (int k = 0; k < 4; k++) msnap[k] = 0;
            malarm  = 1'b0;
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
            exp_dp  = 1'b1;
        end else begin
            int c, i;
            c = pos % DIV;
            i = (pos / DIV) % 4;
            exp_an  = (c < BLANK) ? 4'b1111 : ~(4'b0001 << i);
            exp_seg = dec(msnap[i]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (i == 3 && msnap[3] == 0) exp_seg = 7'b1111111;
`endif
            exp_dp = (i == 2) ? (malarm ? 1'b0 : ~tick_1Hz) : 1'b1;
            if (pos % (4 * DIV) == 4 * DIV - 1) begin
                malarm = show_alarm;
                if (show_alarm) begin
                    msnap[0] = alarm_min_1s;  msnap[1] = alarm_min_10s;
                    msnap[2] = alarm_hr_1s;   msnap[3] = alarm_hr_10s;
                end else begin
                    msnap[0] = min_1s;  msnap[1] = min_10s;
                    msnap[2] = hr_1s;   msnap[3] = hr_10s;
                end
            end
            pos = pos + 1;
        end
    end

    // Every-cycle comparison; seg/dp only matter while a digit is lit.
    always @(negedge clk_100MHz) begin
        n_tests++;
        if (reset) begin
            if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
                n_fail++;
                $display("FAIL model_reset pos=%0d: an=%b seg=%b dp=%b, need 1111 1111111 1", pos, an, seg, dp);
            end
        end else if (an !== exp_an) begin
            n_fail++;
            $display("FAIL model_an pos=%0d: got %b, need %b", pos, an, exp_an);
        end else if (exp_an != 4'b1111 && (seg !== exp_seg || dp !== exp_dp)) begin
            n_fail++;
            $display("FAIL model_seg pos=%0d: seg=%b dp=%b, need seg=%b dp=%b", pos, seg, dp, exp_seg, exp_dp);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic to(input int t);
        int guard;
        guard = 0;
        while (pos < t && guard < 1000) begin
            @(negedge clk_100MHz);
            guard++;
        end
        if (pos != t) begin
            n_tests++; n_fail++;
            $display("FAIL to_edge: at edge %0d, need %0d", pos, t);
        end
    endtask

    task automatic chk(input string nm, input logic [3:0] a_e, input logic [6:0] s_e);
        n_tests++;
        if (an !== a_e || seg !== s_e) begin
            n_fail++;
            $display("FAIL %s: an=%b seg=%b, need an=%b seg=%b", nm, an, seg, a_e, s_e);
        end
    endtask

    task automatic chk_dp(input string nm, input logic d_e);
        n_tests++;
        if (dp !== d_e) begin
            n_fail++;
            $display("FAIL %s: dp=%b, need %b", nm, dp, d_e);
        end
    endtask

    task automatic set_time(input int h10, input int h1, input int m10, input int m1);
        hr_10s = 4'(h10); hr_1s = 4'(h1); min_10s = 4'(m10); min_1s = 4'(m1);
    endtask

    task automatic set_alarm(input int h10, input int h1, input int m10, input int m1);
        alarm_hr_10s = 4'(h10); alarm_hr_1s = 4'(h1); alarm_min_10s = 4'(m10); alarm_min_1s = 4'(m1);
    endtask

    localparam logic [6:0] LZ_SEG =
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        7'b1111111;
`else
        7'b1000000;
`endif

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; tick_1Hz = 1'b0; show_alarm = 1'b0;
        set_time(0, 0, 0, 0);
        set_alarm(0, 0, 0, 0);
        #1;
        chk("reset_state", 4'b1111, 7'b1111111);
        chk_dp("reset_dp", 1'b1);
        @(negedge clk_100MHz);
        @(negedge clk_100MHz);
        set_time(1, 2, 3, 4);
        reset = 1'b0;

        // First frame still shows the cleared snapshot.
        to(3);   chk("first_lit_slot", 4'b1110, 7'b1000000);
        // Frame 2 shows 12:34.
        to(35);  chk("scan_slot0_4", 4'b1110, 7'b0011001);
        min_1s = 4'd7;
        to(39);  chk("coherent_still_4", 4'b1110, 7'b0011001);
        to(43);  chk("scan_slot1_3", 4'b1101, 7'b0110000);
        to(51);  chk("scan_slot2_2", 4'b1011, 7'b0100100);
        to(59);  chk("scan_slot3_1", 4'b0111, 7'b1111001);
        to(67);  chk("next_frame_7", 4'b1110, 7'b1111000);

        // Alarm 06:30, dot steady in slot 2.
        show_alarm = 1'b1; set_alarm(0, 6, 3, 0); tick_1Hz = 1'b1;
        to(99);  chk("alarm_slot0_0", 4'b1110, 7'b1000000);
        to(107); chk("alarm_slot1_3", 4'b1101, 7'b0110000);
        to(117); chk("alarm_slot2_6", 4'b1011, 7'b0000010);
                 chk_dp("alarm_dp_tick1", 1'b0);
        tick_1Hz = 1'b0;
        to(118); chk_dp("alarm_dp_tick0", 1'b0);
        to(125); chk("alarm_slot3_lead0", 4'b0111, LZ_SEG);

        // Back to time mode with an invalid tens-of-minutes digit.
        show_alarm = 1'b0; set_time(0, 2, 12, 7);
        to(131); chk("time_slot0_7", 4'b1110, 7'b1111000);
        to(139); chk("invalid_bcd_dash", 4'b1101, 7'b0111111);
        to(146); tick_1Hz = 1'b1;
        to(147); chk("time_slot2_2", 4'b1011, 7'b0100100);
                 chk_dp("time_dp_tick1", 1'b0);
        tick_1Hz = 1'b0;
        to(148); chk_dp("time_dp_tick0", 1'b1);
        to(157); chk("time_slot3_lead0", 4'b0111, LZ_SEG);

        // Asynchronous reset mid-slot.
        @(posedge clk_100MHz);
        #2 reset = 1'b1;
        #1;
        chk("async_reset", 4'b1111, 7'b1111111);
        chk_dp("async_reset_dp", 1'b1);
        @(negedge clk_100MHz);
        @(negedge clk_100MHz);
        reset = 1'b0;
        to(2);   chk("post_reset_blank", 4'b1111, 7'b1000000);
        to(3);   chk("post_reset_slot0", 4'b1110, 7'b1000000);

        // Free-running mixed traffic, checked by the model alone.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk_100MHz);
            if (n % 5 == 0) tick_1Hz = ~tick_1Hz;
            if (n % 13 == 0)
                set_time($urandom_range(0, 15), $urandom_range(0, 15),
                         $urandom_range(0, 15), $urandom_range(0, 15));
            if (n % 17 == 0)
                set_alarm($urandom_range(0, 2), $urandom_range(0, 9),
                          $urandom_range(0, 5), $urandom_range(0, 9));
            if (n % 41 == 0) show_alarm = ~show_alarm;
        end
        @(negedge clk_100MHz);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
